// File: rtl/appr_divider.sv
`default_nettype none
// ============================================================================
// Module      : appr_divider
// Description : Sequential approximate unsigned divider. Operands are
//               normalised by iterative left shift, truncated to an M-bit
//               mantissa, divided with a W-cycle restoring divider and the
//               quotient is shifted back into place. start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module appr_divider #(
    parameter int W = 16,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,          // asynchronous, active low
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         div_by_zero
);

    // Leading-zero counters and the DIV step counter share this width.
    localparam int c_CNT_W = $clog2(W);
    // Shift amount 8 + lza - lzb held as a two's complement value.
    localparam int c_SH_W  = c_CNT_W + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LZD   = 3'd1,
        S_DIV   = 3'd2,
        S_ALIGN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [c_CNT_W-1:0]   r_lza;
    logic [c_CNT_W-1:0]   r_lzb;
    logic [W-1:0]         r_quo;     // dividend bits shift out, quotient bits shift in
    logic [M-1:0]         r_rem;
    logic [M-1:0]         r_mb;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [W-1:0]         r_result;
    logic                 r_dbz;

    logic                 w_msb_both;
    logic                 w_div_last;
    logic                 w_zero_op;
    logic [M:0]           w_rem_sh;
    logic                 w_ge;
    logic [M-1:0]         w_rem_sub;
    logic [M-1:0]         w_rem_nx;
    logic [c_SH_W-1:0]    w_s;
    logic [c_SH_W-1:0]    w_s_neg;
    logic [W-1:0]         w_aligned;

    assign w_msb_both = r_a[W-1] & r_b[W-1];
    assign w_div_last = (r_cnt == c_CNT_W'(W - 1));
    assign w_zero_op  = (a_in == '0) || (b_in == '0);

    // One restoring-division step: bring down the next dividend bit and
    // subtract the divisor mantissa when it fits. The partial remainder is
    // always below mb, so the low M bits of the difference are exact.
    assign w_rem_sh  = {r_rem, r_quo[W-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_mb});
    assign w_rem_sub = w_rem_sh[M-1:0] - r_mb;
    assign w_rem_nx  = w_ge ? w_rem_sub : w_rem_sh[M-1:0];

    // Realignment: s = M + lza - lzb, right shift when s >= 0, otherwise
    // left shift by -s (at most 7, so the 9-bit quotient cannot overflow).
    assign w_s       = c_SH_W'(M) + {2'b00, r_lza} - {2'b00, r_lzb};
    assign w_s_neg   = c_SH_W'(0) - w_s;
    assign w_aligned = w_s[c_SH_W-1] ? (r_quo << w_s_neg) : (r_quo >> w_s);

    assign result      = r_result;
    assign div_by_zero = r_dbz;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake outputs. Zero operands take the short
    // path through ALIGN so every result is loaded on the same DONE-entry edge.
    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = w_zero_op ? S_ALIGN : S_LZD;
                end
            end
            S_LZD: begin
                if (w_msb_both) begin
                    w_next = S_DIV;
                end
            end
            S_DIV: begin
                if (w_div_last) begin
                    w_next = S_ALIGN;
                end
            end
            S_ALIGN: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, normalisation, division and realignment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_lza    <= '0;
            r_lzb    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_mb     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a_in;
                        r_b   <= b_in;
                        r_lza <= '0;
                        r_lzb <= '0;
                    end
                end
                S_LZD: begin
                    if (w_msb_both) begin
                        r_quo <= {r_a[W-1:W-M], {(W-M){1'b0}}};
                        r_mb  <= r_b[W-1:W-M];
                        r_rem <= '0;
                        r_cnt <= '0;
                    end else begin
                        if (!r_a[W-1]) begin
                            r_a   <= r_a << 1;
                            r_lza <= r_lza + c_CNT_W'(1);
                        end
                        if (!r_b[W-1]) begin
                            r_b   <= r_b << 1;
                            r_lzb <= r_lzb + c_CNT_W'(1);
                        end
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= {r_quo[W-2:0], w_ge};
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                S_ALIGN: begin
                    // Normalised operands are never zero, so these tests
                    // only fire on the short path from IDLE.
                    if (r_b == '0) begin
                        r_result <= '1;
                        r_dbz    <= 1'b1;
                    end else if (r_a == '0) begin
                        r_result <= '0;
                        r_dbz    <= 1'b0;
                    end else begin
                        r_result <= w_aligned;
                        r_dbz    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
